// File: rtl/fd_datapath_if.sv
// fd_datapath_if: operand selection, control and read-data signals of the datapath
interface fd_datapath_if;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [4:0]  Rw;
    logic        WE_reg;
    logic        WE_mem;
    logic [63:0] OFFSET;
    logic        ADD_SUB;
    logic        OP_MEM;
    logic [63:0] doutA;
    logic [63:0] doutB;
    logic [63:0] doutMem;

    modport master (
        output Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, ADD_SUB, OP_MEM,
        input  doutA, doutB, doutMem
    );

    modport slave (
        input  Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, ADD_SUB, OP_MEM,
        output doutA, doutB, doutMem
    );
endinterface

// File: rtl/fd_datapath.sv
// fd_datapath: single-cycle 32x64 register file, add/sub ALU and 32x64 data memory
module fd_datapath (
    input logic         clk,
    input logic         rst_n,
    fd_datapath_if.slave bus
);
    logic [63:0] regs [32];
    logic [63:0] mem  [32];
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [4:0]  idx;

    assign bus.doutA   = bus.Ra == 5'd0 ? 64'd0 : regs[bus.Ra];
    assign bus.doutB   = bus.Rb == 5'd0 ? 64'd0 : regs[bus.Rb];
    assign alu         = bus.OP_MEM  ? bus.doutB + bus.OFFSET :
                         bus.ADD_SUB ? bus.doutA - bus.doutB : bus.doutA + bus.doutB;
    assign idx         = alu[4:0];
    assign bus.doutMem = mem[idx];
    assign wdata       = bus.OP_MEM ? bus.doutMem : alu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) regs[k] <= 64'd0;
        end else if (bus.WE_reg && bus.Rw != 5'd0) begin
            regs[bus.Rw] <= wdata;
        end
    end

    // reset preloads each word with 100+k so loads are observable right after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) mem[k] <= 64'(100 + k);
        end else if (bus.WE_mem) begin
            mem[idx] <= bus.doutA;
        end
    end
endmodule

// File: tb/tb_fd_datapath.sv
// tb_fd_datapath: table-driven directed vectors plus reset-during-write sequence
module tb_fd_datapath;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fd_datapath_if bus ();
    fd_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic [4:0]  ra, rb, rw;
        logic        we_reg, we_mem;
        logic [63:0] off;
        logic        add_sub, op_mem;
        logic [63:0] exp_a, exp_b, exp_mem;
    } vec_t;

    vec_t tbl [16];
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input logic we_reg, input logic we_mem, input logic [63:0] off,
                         input logic add_sub, input logic op_mem);
        bus.Ra = ra; bus.Rb = rb; bus.Rw = rw;
        bus.WE_reg = we_reg; bus.WE_mem = we_mem;
        bus.OFFSET = off; bus.ADD_SUB = add_sub; bus.OP_MEM = op_mem;
    endtask

    task automatic peek_mem(input logic [63:0] off, input logic [63:0] exp, input string name);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, off, 1'b0, 1'b1);
        #2;
        chk(name, bus.doutMem, exp);
    endtask

    initial begin
        tbl[0]  = '{"load_w0",      5'd0, 5'd0, 5'd1, 1, 0, 64'd0,  0, 1, 64'd0,   64'd0,   64'd100};
        tbl[1]  = '{"load_w1",      5'd0, 5'd0, 5'd2, 1, 0, 64'd1,  0, 1, 64'd0,   64'd0,   64'd101};
        tbl[2]  = '{"add_x2_x1",    5'd2, 5'd1, 5'd3, 1, 0, 64'd0,  0, 0, 64'd101, 64'd100, 64'd109};
        tbl[3]  = '{"sub_x3_x1",    5'd3, 5'd1, 5'd4, 1, 0, 64'd0,  1, 0, 64'd201, 64'd100, 64'd105};
        tbl[4]  = '{"store_x3_w2",  5'd3, 5'd0, 5'd0, 0, 1, 64'd2,  0, 1, 64'd201, 64'd0,   64'd102};
        tbl[5]  = '{"store_x4_w3",  5'd4, 5'd0, 5'd0, 0, 1, 64'd3,  0, 1, 64'd101, 64'd0,   64'd103};
        tbl[6]  = '{"readback_w2",  5'd0, 5'd0, 5'd0, 0, 0, 64'd2,  0, 1, 64'd0,   64'd0,   64'd201};
        tbl[7]  = '{"readback_w3",  5'd0, 5'd0, 5'd0, 0, 0, 64'd3,  0, 1, 64'd0,   64'd0,   64'd101};
        tbl[8]  = '{"write_x0",     5'd0, 5'd1, 5'd0, 1, 0, 64'd0,  0, 0, 64'd0,   64'd100, 64'd104};
        tbl[9]  = '{"wrap_off33",   5'd0, 5'd0, 5'd0, 0, 0, 64'd33, 0, 1, 64'd0,   64'd0,   64'd101};
        tbl[10] = '{"sub_underflow",5'd1, 5'd2, 5'd5, 1, 0, 64'd0,  1, 0, 64'd100, 64'd101, 64'd131};
        tbl[11] = '{"read_x5",      5'd5, 5'd0, 5'd0, 0, 0, 64'd0,  0, 1, ONES,    64'd0,   64'd100};
        tbl[12] = '{"ld_st_same",   5'd3, 5'd0, 5'd6, 1, 1, 64'd4,  0, 1, 64'd201, 64'd0,   64'd104};
        tbl[13] = '{"after_ld_st",  5'd6, 5'd0, 5'd0, 0, 0, 64'd4,  0, 1, 64'd104, 64'd0,   64'd201};
        tbl[14] = '{"we_low",       5'd4, 5'd4, 5'd7, 0, 0, 64'd0,  0, 0, 64'd101, 64'd101, 64'd110};
        tbl[15] = '{"x7_unwritten", 5'd7, 5'd0, 5'd0, 0, 0, 64'd4,  0, 1, 64'd0,   64'd0,   64'd201};

        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 64'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        #2;
        chk("reset_doutA", bus.doutA, 64'd0);
        chk("reset_doutB", bus.doutB, 64'd0);
        chk("reset_doutMem", bus.doutMem, 64'd100);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].we_reg, tbl[i].we_mem,
                  tbl[i].off, tbl[i].add_sub, tbl[i].op_mem);
            #2;
            chk({tbl[i].name, "_doutA"},   bus.doutA,   tbl[i].exp_a);
            chk({tbl[i].name, "_doutB"},   bus.doutB,   tbl[i].exp_b);
            chk({tbl[i].name, "_doutMem"}, bus.doutMem, tbl[i].exp_mem);
            @(posedge clk);
            #1;
        end

        // reset asserted while both writes are requested
        rst_n = 1'b0;
        drive(5'd3, 5'd0, 5'd8, 1'b1, 1'b1, 64'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'd3, 5'd6, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        chk("rst_mid_x3", bus.doutA, 64'd0);
        chk("rst_mid_x6", bus.doutB, 64'd0);
        drive(5'd8, 5'd5, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        #2;
        chk("rst_mid_x8", bus.doutA, 64'd0);
        chk("rst_mid_x5", bus.doutB, 64'd0);
        peek_mem(64'd2,  64'd102, "rst_mid_w2");
        peek_mem(64'd4,  64'd104, "rst_mid_w4");
        peek_mem(64'd31, 64'd131, "rst_mid_w31");
        @(posedge clk);
        #1;
        peek_mem(64'd2,  64'd102, "idle_w2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fd_datapath.md
FD_DATAPATH -- requirements
Module: fd_datapath

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: Ra  input  5  register-file read address A; A supplies ALU operand A and store data.
REQ-004 SHALL have port: Rb  input  5  register-file read address B; B supplies ALU operand B and address base.
REQ-005 SHALL have port: Rw  input  5  register-file write address.
REQ-006 SHALL have port: WE_reg  input  1  register-file write enable.
REQ-007 SHALL have port: WE_mem  input  1  data-memory write enable.
REQ-008 SHALL have port: OFFSET  input  64  immediate address offset.
REQ-009 SHALL have port: ADD_SUB  input  1  ALU operation: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port: OP_MEM  input  1  1 = memory operation (address calculation, register write from memory); 0 = ALU register-register operation.
REQ-011 SHALL have port: doutA  output  64  register-file contents at Ra.
REQ-012 SHALL have port: doutB  output  64  register-file contents at Rb.
REQ-013 SHALL have port: doutMem  output  64  data-memory contents at the current effective address.

Function
REQ-014 SHALL contain a register file of 32 x 64-bit registers; register x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-015 doutA and doutB SHALL be combinational reads; a same-cycle write SHALL be visible only after the clock edge.
REQ-016 ALU result SHALL be computed as follows:
- OP_MEM=1: doutB + OFFSET.
- OP_MEM=0, ADD_SUB=0: doutA + doutB.
- OP_MEM=0, ADD_SUB=1: doutA - doutB.
- All arithmetic is 64-bit modulo 2^64, with no flags.
REQ-017 SHALL contain a data memory of 32 x 64-bit words, indexed by ALU result[4:0]; upper bits SHALL be ignored, so addresses wrap.
REQ-018 doutMem SHALL be a combinational read of the memory word at the current index.
REQ-019 On a rising edge with rst_n=1 and WE_mem=1, memory[index] SHALL take the value of doutA (Ra contents). This applies regardless of OP_MEM.
REQ-020 Register write data SHALL be doutMem when OP_MEM=1 and the ALU result when OP_MEM=0.
REQ-021 On a rising edge with rst_n=1, WE_reg=1 and Rw≠0, register[Rw] SHALL take the write data.
REQ-022 Simultaneous WE_reg and WE_mem SHALL both take effect on the same edge.
- Each uses values sampled before the edge.
- A load and store to the same word SHALL load the old memory value.
REQ-023 Write-enables low SHALL leave all state unchanged; there is no pipeline, and every operation completes in one cycle.

Reset
REQ-024 On a rising edge with rst_n=0, the block SHALL:
- clear all registers to 0;
- set memory word k to 100+k (k = 0..31);
- ignore WE_reg and WE_mem on that edge.
REQ-025 Outputs SHALL be derived from state only, with no separate reset values. After reset:
- doutA = doutB = 0;
- doutMem = memory word at the current index, e.g. 100 when OP_MEM=1, Rb=0, OFFSET=0.

Verification
REQ-026 Load: reset; OP_MEM=1, Rb=0, OFFSET=0, Rw=1, WE_reg=1 for one edge; then OFFSET=1, Rw=2 for one edge -> x1=100, x2=101, and doutMem shows 101 before the second edge.
REQ-027 Add: after REQ-026, OP_MEM=0, ADD_SUB=0, Ra=2, Rb=1, Rw=3, WE_reg=1 -> x3=201. Then ADD_SUB=1, Ra=3, Rb=1, Rw=4 -> x4=101.
REQ-028 Store: OP_MEM=1, WE_reg=0, WE_mem=1, Rb=0, Ra=3, OFFSET=2 -> memory[2]=201. Then Ra=4, OFFSET=3 -> memory[3]=101. With WE_mem=0, doutMem reads back 201 at OFFSET=2.
REQ-029 Boundaries:
- WE_reg=1, Rw=0 -> doutA at Ra=0 stays 0.
- OFFSET=33 with Rb=0 -> accesses word 1 (value 101 after reset).
- Subtract 100-101 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-030 Reset mid-operation: WE_reg=1 and WE_mem=1 asserted with rst_n=0 -> registers all 0, memory restored to 100+k, no write performed.
